// File: rtl/status_frame_tx_if.sv
// Bus between a status-report transmitter and its owner: frame request,
// status inputs to snapshot, and the serial line plus handshake outputs.
interface status_frame_tx_if;
    logic       req;
    logic       switch;
    logic       io_a;
    logic       io_b;
    logic       error;
    logic       force_swi;
    logic       com_swi;
    logic       stx;
    logic       busy;
    logic       frame_done;
    logic [7:0] seq;

    modport master (
        output req, switch, io_a, io_b, error, force_swi, com_swi,
        input  stx, busy, frame_done, seq
    );

    modport slave (
        input  req, switch, io_a, io_b, error, force_swi, com_swi,
        output stx, busy, frame_done, seq
    );
endinterface

// File: rtl/status_frame_tx.sv
// Periodic / on-demand 5-byte status frame sender (UART 8N1, LSB first):
// header EB 90, status byte, sequence number, XOR checksum.
module status_frame_tx #(
    parameter int unsigned CLK_DIV = 434,
    parameter int unsigned PERIOD  = 5000000,
    parameter logic [7:0]  HDR0    = 8'hEB,
    parameter logic [7:0]  HDR1    = 8'h90
) (
    input  logic              clk,
    input  logic              rst,
    status_frame_tx_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

    localparam logic [15:0] DIV_LAST    = 16'(CLK_DIV - 1);
    localparam logic [31:0] PERIOD_LAST = (PERIOD == 0) ? 32'd0 : 32'(PERIOD - 1);

    state_t      state, state_next;
    logic [15:0] bit_timer;
    logic [2:0]  bit_cnt;
    logic [2:0]  byte_idx;
    logic [31:0] period_cnt;
    logic        tick;
    logic        pending;
    logic        start_frame;
    logic        bit_end;
    logic [7:0]  snap_status;
    logic [7:0]  snap_seq;
    logic [7:0]  cur_byte;
    logic        stx_q;
    logic        busy_q;
    logic        done_q;
    logic [7:0]  seq_q;

    assign bus.stx        = stx_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;
    assign bus.seq        = seq_q;

    // Free-running period timer; it keeps counting while a frame is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_cnt <= '0;
        end else if (PERIOD == 0 || period_cnt == PERIOD_LAST) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 32'd1;
        end
    end

    assign tick = (PERIOD != 0) && (period_cnt == PERIOD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        bit_end     = (bit_timer == DIV_LAST);
        case (state)
            IDLE: begin
                if (bus.req || tick || pending) begin
                    state_next  = START;
                    start_frame = 1'b1;
                end
            end
            START: if (bit_end) state_next = DATA;
            DATA:  if (bit_end && bit_cnt == 3'd7) state_next = STOP;
            STOP:  if (bit_end) state_next = (byte_idx == 3'd4) ? DONE : START;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cur_byte = HDR0;
        case (byte_idx)
            3'd0:    cur_byte = HDR0;
            3'd1:    cur_byte = HDR1;
            3'd2:    cur_byte = snap_status;
            3'd3:    cur_byte = snap_seq;
            3'd4:    cur_byte = HDR0 ^ HDR1 ^ snap_status ^ snap_seq;
            default: cur_byte = HDR0;
        endcase
    end

    // stx follows the state one cycle late, so the line only ever changes from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_timer   <= '0;
            bit_cnt     <= '0;
            byte_idx    <= '0;
            snap_status <= '0;
            snap_seq    <= '0;
            stx_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            seq_q       <= '0;
            pending     <= 1'b0;
        end else begin
            done_q <= (state == DONE);

            if (state == IDLE || state == DONE || bit_end) begin
                bit_timer <= '0;
            end else begin
                bit_timer <= bit_timer + 16'd1;
            end

            case (state)
                START:   stx_q <= 1'b0;
                DATA:    stx_q <= cur_byte[bit_cnt];
                default: stx_q <= 1'b1;
            endcase

            if (state == IDLE) begin
                pending <= 1'b0;
            end else if (bus.req || tick) begin
                pending <= 1'b1;
            end

            if (start_frame) begin
                snap_status <= {bus.switch, bus.io_a, bus.io_b, bus.error,
                                bus.force_swi, bus.com_swi, 2'b00};
                snap_seq    <= seq_q;
                busy_q      <= 1'b1;
                byte_idx    <= '0;
                bit_cnt     <= '0;
            end

            if (state == DATA && bit_end) begin
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (state == STOP && bit_end && byte_idx != 3'd4) begin
                byte_idx <= byte_idx + 3'd1;
            end

            // Busy stays up through DONE when another frame is already queued.
            if (state == DONE) begin
                busy_q <= pending || bus.req || tick;
                seq_q  <= seq_q + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_status_frame_tx.sv
// Directed bench for status_frame_tx: decodes the serial line back into bytes
// and compares against hand-computed frames, timing and handshake values.
module tb_status_frame_tx;
    localparam logic [7:0] HDR0 = 8'hEB;
    localparam logic [7:0] HDR1 = 8'h90;

    typedef struct {
        logic       sw;
        logic       ia;
        logic       ib;
        logic       err;
        logic       fsw;
        logic       csw;
        logic [7:0] exp_status;
        logic [7:0] exp_chk;
    } vec_t;

    logic clk;
    logic rst_a;
    logic rst_b;
    logic sel_b;
    logic mon_stx;
    int   checks;
    int   errors;

    status_frame_tx_if bus_a ();
    status_frame_tx_if bus_b ();

    status_frame_tx #(.CLK_DIV(4), .PERIOD(0), .HDR0(HDR0), .HDR1(HDR1)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    status_frame_tx #(.CLK_DIV(4), .PERIOD(1000), .HDR0(HDR0), .HDR1(HDR1)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb mon_stx = sel_b ? bus_b.stx : bus_a.stx;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] expChk(input logic [7:0] st, input logic [7:0] sq);
        return HDR0 ^ HDR1 ^ st ^ sq;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulseReq(input bit on_b);
        @(negedge clk);
        if (on_b) bus_b.req = 1'b1; else bus_a.req = 1'b1;
        @(negedge clk);
        if (on_b) bus_b.req = 1'b0; else bus_a.req = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        bus_a.switch    = v.sw;
        bus_a.io_a      = v.ia;
        bus_a.io_b      = v.ib;
        bus_a.error     = v.err;
        bus_a.force_swi = v.fsw;
        bus_a.com_swi   = v.csw;
        bus_a.req       = 1'b1;
        @(negedge clk);
        bus_a.req = 1'b0;
    endtask

    // Waits for a start bit, then requires every bit to hold for exactly 4 samples.
    task automatic captureFrame(input int max_wait, output logic [39:0] frame_o,
                                output int waited, output bit ok);
        logic [9:0] sym;
        logic       v;
        bit         found;
        ok      = 1'b1;
        found   = 1'b0;
        waited  = 0;
        frame_o = '0;
        sym     = '0;
        v       = 1'b1;
        while (!found && waited < max_wait) begin
            @(negedge clk);
            if (mon_stx === 1'b0) found = 1'b1;
            else waited++;
        end
        if (!found) begin
            ok = 1'b0;
            return;
        end
        for (int b = 0; b < 5; b++) begin
            for (int k = 0; k < 10; k++) begin
                for (int c = 0; c < 4; c++) begin
                    if (!(b == 0 && k == 0 && c == 0)) @(negedge clk);
                    if (c == 0) v = mon_stx;
                    else if (mon_stx !== v) ok = 1'b0;
                end
                sym[k] = v;
            end
            if (sym[0] !== 1'b0 || sym[9] !== 1'b1) ok = 1'b0;
            frame_o[8*b +: 8] = sym[8:1];
        end
    endtask

    task automatic checkFrame(input string tag, input logic [39:0] f, input logic [7:0] st,
                              input logic [7:0] sq, input logic [7:0] chk);
        checkOutput({tag, "_hdr0"},   {24'd0, f[7:0]},   {24'd0, HDR0});
        checkOutput({tag, "_hdr1"},   {24'd0, f[15:8]},  {24'd0, HDR1});
        checkOutput({tag, "_status"}, {24'd0, f[23:16]}, {24'd0, st});
        checkOutput({tag, "_seq"},    {24'd0, f[31:24]}, {24'd0, sq});
        checkOutput({tag, "_chk"},    {24'd0, f[39:32]}, {24'd0, chk});
    endtask

    task automatic waitIdle(input int limit);
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (bus_a.busy === 1'b0) break;
        end
    endtask

    initial begin
        vec_t        vecs [6];
        vec_t        v_c0;
        vec_t        v_40;
        logic [39:0] fr;
        int          w;
        bit          ok;
        int          lows;

        vecs[0] = '{1, 1, 0, 0, 0, 0, 8'hC0, 8'hBB};
        vecs[1] = '{0, 0, 1, 1, 0, 0, 8'h30, 8'h4A};
        vecs[2] = '{0, 0, 0, 0, 1, 1, 8'h0C, 8'h75};
        vecs[3] = '{1, 1, 1, 1, 1, 1, 8'hFC, 8'h84};
        vecs[4] = '{0, 0, 0, 0, 0, 0, 8'h00, 8'h7F};
        vecs[5] = '{1, 0, 0, 1, 0, 1, 8'h94, 8'hEA};
        v_c0    = '{1, 1, 0, 0, 0, 0, 8'hC0, 8'hBB};
        v_40    = '{0, 1, 0, 0, 0, 0, 8'h40, 8'h00};

        checks = 0;
        errors = 0;
        sel_b  = 1'b0;
        rst_a  = 1'b1;
        rst_b  = 1'b1;
        {bus_a.req, bus_a.switch, bus_a.io_a, bus_a.io_b, bus_a.error, bus_a.force_swi, bus_a.com_swi} = '0;
        {bus_b.req, bus_b.switch, bus_b.io_a, bus_b.io_b, bus_b.error, bus_b.force_swi, bus_b.com_swi} = '0;
        bus_b.io_b = 1'b1;

        repeat (3) @(negedge clk);
        checkOutput("rst_stx",   bus_a.stx, 1);
        checkOutput("rst_busy",  bus_a.busy, 0);
        checkOutput("rst_done",  bus_a.frame_done, 0);
        checkOutput("rst_seq",   bus_a.seq, 0);
        checkOutput("rst_stx_b", bus_b.stx, 1);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Periodic frames on the PERIOD=1000 instance, status 0x20
        $display("[TB] periodic frames");
        sel_b = 1'b1;
        captureFrame(1100, fr, w, ok);
        checkOutput("per0_ok", ok, 1);
        checkOutput("per0_phase", w, 1000);
        checkFrame("per0", fr, 8'h20, 8'h00, expChk(8'h20, 8'h00));
        for (int p = 1; p < 3; p++) begin
            captureFrame(1100, fr, w, ok);
            checkOutput($sformatf("per%0d_ok", p), ok, 1);
            checkOutput($sformatf("per%0d_gap", p), w, 800);
            checkFrame($sformatf("per%0d", p), fr, 8'h20, 8'(p), expChk(8'h20, 8'(p)));
        end
        repeat (799) @(negedge clk);
        bus_b.req = 1'b1;
        @(negedge clk);
        bus_b.req = 1'b0;
        captureFrame(10, fr, w, ok);
        checkOutput("coinc_ok", ok, 1);
        checkOutput("coinc_start", w, 0);
        checkFrame("coinc", fr, 8'h20, 8'h03, expChk(8'h20, 8'h03));
        captureFrame(1100, fr, w, ok);
        checkOutput("coinc_single_gap", w, 800);
        checkFrame("per4", fr, 8'h20, 8'h04, expChk(8'h20, 8'h04));
        rst_b = 1'b1;
        sel_b = 1'b0;

        $display("[TB] table vectors");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_busy_start", i), bus_a.busy, 1);
            checkOutput($sformatf("vec%0d_stx_latency", i), bus_a.stx, 1);
            captureFrame(10, fr, w, ok);
            checkOutput($sformatf("vec%0d_ok", i), ok, 1);
            checkOutput($sformatf("vec%0d_start", i), w, 0);
            checkFrame($sformatf("vec%0d", i), fr, vecs[i].exp_status, 8'(i), vecs[i].exp_chk);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_done", i), bus_a.frame_done, 1);
            checkOutput($sformatf("vec%0d_busy_end", i), bus_a.busy, 0);
            checkOutput($sformatf("vec%0d_seq", i), bus_a.seq, i + 1);
        end

        $display("[TB] requests while busy");
        applyStimulus(v_c0);
        fork
            captureFrame(10, fr, w, ok);
            begin
                repeat (20) @(negedge clk);
                pulseReq(0);
                repeat (40) @(negedge clk);
                pulseReq(0);
                repeat (60) @(negedge clk);
                pulseReq(0);
            end
        join
        checkOutput("pend1_ok", ok, 1);
        checkFrame("pend1", fr, 8'hC0, 8'h06, expChk(8'hC0, 8'h06));
        @(negedge clk);
        checkOutput("pend_done", bus_a.frame_done, 1);
        checkOutput("pend_busy_gap0", bus_a.busy, 1);
        @(negedge clk);
        checkOutput("pend_busy_gap1", bus_a.busy, 1);
        checkOutput("pend_stx_gap1", bus_a.stx, 1);
        captureFrame(10, fr, w, ok);
        checkOutput("pend2_ok", ok, 1);
        checkOutput("pend2_start", w, 0);
        checkFrame("pend2", fr, 8'hC0, 8'h07, expChk(8'hC0, 8'h07));
        @(negedge clk);
        checkOutput("pend2_done", bus_a.frame_done, 1);
        lows = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus_a.stx !== 1'b1 || bus_a.busy !== 1'b0) lows++;
        end
        checkOutput("no_third_frame", lows, 0);

        $display("[TB] status snapshot");
        applyStimulus(v_40);
        fork
            captureFrame(10, fr, w, ok);
            begin
                repeat (90) @(negedge clk);
                bus_a.switch = 1'b1;
                bus_a.error  = 1'b1;
            end
        join
        checkOutput("snap_ok", ok, 1);
        checkFrame("snap", fr, 8'h40, 8'h08, expChk(8'h40, 8'h08));
        waitIdle(10);
        pulseReq(0);
        captureFrame(10, fr, w, ok);
        checkOutput("snap_next_ok", ok, 1);
        checkFrame("snap_next", fr, 8'hD0, 8'h09, expChk(8'hD0, 8'h09));
        waitIdle(10);

        $display("[TB] reset mid-frame");
        applyStimulus(v_c0);
        repeat (135) @(negedge clk);
        rst_a = 1'b1;
        #1;
        checkOutput("midrst_stx",  bus_a.stx, 1);
        checkOutput("midrst_busy", bus_a.busy, 0);
        checkOutput("midrst_seq",  bus_a.seq, 0);
        @(negedge clk);
        rst_a = 1'b0;
        lows = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus_a.stx !== 1'b1 || bus_a.busy !== 1'b0) lows++;
        end
        checkOutput("midrst_quiet", lows, 0);
        pulseReq(0);
        captureFrame(10, fr, w, ok);
        checkOutput("midrst_ok", ok, 1);
        checkOutput("midrst_start", w, 0);
        checkFrame("midrst", fr, 8'hC0, 8'h00, 8'hBB);
        waitIdle(10);

        $display("[TB] sequence wrap");
        for (int n = 0; n < 300 && bus_a.seq != 8'hFF; n++) begin
            pulseReq(0);
            waitIdle(400);
        end
        checkOutput("seq_before_wrap", bus_a.seq, 8'hFF);
        pulseReq(0);
        captureFrame(10, fr, w, ok);
        checkOutput("wrap_ok", ok, 1);
        checkFrame("wrap", fr, 8'hC0, 8'hFF, 8'h44);
        @(negedge clk);
        checkOutput("wrap_done", bus_a.frame_done, 1);
        checkOutput("seq_after_wrap", bus_a.seq, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/status_frame_tx.md
Name: status_frame_tx

Overview:
Serial status-report transmitter: the outgoing counterpart of the command receive path on the comm links.
- Builds a fixed 5-byte status frame and serializes it as UART 8N1 LSB-first on one stx line.
- Frames are sent periodically and on demand (e.g. after a switchover or an error command).
- Instantiated once per comm link (stx_c, stx_d); both copies take the same core/command status inputs.

Parameters:
CLK_DIV, 434, clk cycles per serial bit (50 MHz / 115200); legal range 2..65535
PERIOD, 5000000, clk cycles between periodic frame requests (100 ms); 0 disables periodic frames
HDR0, 8'hEB, first header byte
HDR1, 8'h90, second header byte

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous reset, active-high
req  input  1  one-cycle pulse: request one frame
switch  input  1  current host select (0 = CPU A, 1 = CPU B)
io_a  input  1  CPU A PWM alive
io_b  input  1  CPU B PWM alive
error  input  1  last command frame erroneous
force_swi  input  1  forced-switch active
com_swi  input  1  command-switch active
stx  output  1  serial data out, idle high
busy  output  1  high from frame start until frame_done
frame_done  output  1  one-cycle pulse after the last stop bit
seq  output  8  sequence number of the next frame to send

Behaviour:
- Reset (async, immediate): stx=1, busy=0, frame_done=0, seq=0, pending=0, period timer=0, state=IDLE. A reset mid-frame aborts the frame; stx returns high at once and no partial frame resumes.
- Frame byte order: B0=HDR0, B1=HDR1, B2=status, B3=seq, B4=B0^B1^B2^B3.
- Status byte B2 = {switch, io_a, io_b, error, force_swi, com_swi, 2'b00}, MSB first.
  - Snapshot of status and seq is taken on the edge that starts the frame.
  - Input changes during a frame do not affect that frame.
- Period timer:
  - Free-running 0..PERIOD-1.
  - At terminal count it raises an internal tick and wraps to 0.
  - Runs regardless of busy. Inactive when PERIOD=0.
- Start condition: in IDLE, a frame starts on any edge where req=1, tick=1, or pending=1.
  - Start actions: capture snapshot, busy<=1, clear pending, go to START.
  - Latency: stx falls on the edge after the edge that samples req (1 cycle).
- Request while busy: req or tick sets pending (1-deep; any number of extra requests collapse to a single extra frame).
  - A request arriving on the same edge as frame_done also sets pending.
- States:
  - IDLE: stx=1.
  - START: stx=0 for CLK_DIV cycles.
  - DATA: 8 bits, LSB first, each held CLK_DIV cycles.
  - STOP: stx=1 for CLK_DIV cycles.
  - After STOP: if byte index < 4, increment the index and go to START with no idle gap. Otherwise go to DONE.
  - DONE (one cycle): frame_done=1, busy<=0, seq<=seq+1 (mod 256, 255 wraps to 0), return to IDLE.
- Timing: frame length = 50*CLK_DIV cycles of line time plus 1 DONE cycle.
  - With pending set, the next start bit begins 2 cycles after the previous stop bit ends (DONE + IDLE start edge).
- Bit timer: counter 0..CLK_DIV-1, width 16 bits. Bit counter 0..7. Byte index 0..4.
- stx is driven from a register (glitch-free).

Test Plan:
- CLK_DIV=4, PERIOD=0; after reset, switch=1, io_a=1, others 0; pulse req.
  -> stx bytes EB 90 C0 00 BB (checksum = EB^90^C0^00).
  -> Each bit exactly 4 cycles; start bit falls 1 cycle after req.
  -> frame_done pulses at cycle 201 after the first start edge; seq=1 afterwards.
- Pulse req 3 times while busy.
  -> Exactly one extra frame, seq byte 01, checksum EB^90^status^01.
  -> No third frame; busy stays high across the 2-cycle gap.
- CLK_DIV=4, PERIOD=1000, no req.
  -> Frame starts every 1000 cycles; seq increments 0,1,2...
  -> A req coinciding with tick yields a single frame.
- Force seq to 255 (send 255 frames); send the next frame.
  -> Frame carries seq FF with checksum EB^90^status^FF; seq then wraps to 00.
- Toggle switch and error during byte 2 of a frame.
  -> Transmitted status equals the value at frame start; the next frame reflects the new values.
- Assert rst mid-DATA of byte 3.
  -> stx=1, busy=0, seq=0 immediately.
  -> After release, a req produces a complete fresh frame with seq 00.
